// File: rtl/queue_pkg.sv
// queue_pkg: shared constants for the parametrised word queue.
// Overflow policies and drop counter width.
package queue_pkg;

    localparam int Q_DROP_NEW      = 0;
    localparam int Q_OVERWRITE_OLD = 1;
    localparam int DROP_CNT_W      = 8;

endpackage

// File: rtl/queue_ram.sv
// queue_ram: WIDTH x SIZE storage for queue_fifo.
// Synchronous write, asynchronous read; contents are not reset.
module queue_ram #(
    parameter int WIDTH    = 8,
    parameter int SIZE     = 16,
    parameter int ADDRSIZE = $clog2(SIZE)
) (
    input  logic                clk,
    input  logic                i_we,
    input  logic [ADDRSIZE-1:0] i_waddr,
    input  logic [WIDTH-1:0]    i_wdata,
    input  logic [ADDRSIZE-1:0] i_raddr,
    output logic [WIDTH-1:0]    o_rdata
);

    logic [WIDTH-1:0] r_mem [SIZE];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/queue_fifo.sv
// queue_fifo: single-clock first-word-fall-through FIFO with selectable
// overflow policy, sticky overflow flag and saturating drop counter.
module queue_fifo
    import queue_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int SIZE         = 16,
    parameter int OVERWRITE    = Q_DROP_NEW,
    parameter int AFULL_THRESH = SIZE - 2,
    parameter int ADDRSIZE     = $clog2(SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_en,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_available,
    input  logic                  out_ack,
    output logic [ADDRSIZE:0]     level,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow,
    input  logic                  overflow_clr,
    output logic [DROP_CNT_W-1:0] drop_count
);

    localparam bit                  LP_OW    = (OVERWRITE == Q_OVERWRITE_OLD);
    localparam logic [ADDRSIZE:0]   LP_SIZE  = (ADDRSIZE+1)'(SIZE);
    localparam logic [ADDRSIZE:0]   LP_AFULL = (ADDRSIZE+1)'(AFULL_THRESH);
    localparam logic [ADDRSIZE:0]   LP_L1    = (ADDRSIZE+1)'(1);
    localparam logic [ADDRSIZE-1:0] LP_P1    = ADDRSIZE'(1);
    localparam logic [DROP_CNT_W-1:0] LP_DMAX = '1;

    logic [ADDRSIZE-1:0]   r_wr_ptr;
    logic [ADDRSIZE-1:0]   r_rd_ptr;
    logic [ADDRSIZE:0]     r_level;
    logic                  r_overflow;
    logic [DROP_CNT_W-1:0] r_drops;

    logic w_full;
    logic w_avail;
    logic w_pop;
    logic w_push;
    logic w_ovf_evt;
    logic w_ow;
    logic w_we;

    assign w_full    = (r_level == LP_SIZE);
    assign w_avail   = (r_level != '0);
    assign w_pop     = out_ack & w_avail;
    assign w_push    = in_en & (~w_full | w_pop);
    assign w_ovf_evt = in_en & w_full & ~w_pop;
    // Overwrite-oldest writes over the head slot and drags rd_ptr along.
    assign w_ow      = w_ovf_evt & LP_OW;
    assign w_we      = w_push | w_ow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_drops    <= '0;
        end else begin
            if (w_we) begin
                r_wr_ptr <= r_wr_ptr + LP_P1;
            end
            if (w_pop | w_ow) begin
                r_rd_ptr <= r_rd_ptr + LP_P1;
            end
            if (w_push & ~w_pop) begin
                r_level <= r_level + LP_L1;
            end else if (w_pop & ~w_push) begin
                r_level <= r_level - LP_L1;
            end
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end else if (overflow_clr) begin
                r_overflow <= 1'b0;
            end
            if (w_ovf_evt && r_drops != LP_DMAX) begin
                r_drops <= r_drops + 1'b1;
            end
        end
    end

    queue_ram #(
        .WIDTH   (WIDTH),
        .SIZE    (SIZE),
        .ADDRSIZE(ADDRSIZE)
    ) u_ram (
        .clk    (clk),
        .i_we   (w_we & ~rst),
        .i_waddr(r_wr_ptr),
        .i_wdata(in_data),
        .i_raddr(r_rd_ptr),
        .o_rdata(out_data)
    );

    assign out_available = w_avail;
    assign level         = r_level;
    assign full          = w_full;
    assign almost_full   = (r_level >= LP_AFULL);
    assign overflow      = r_overflow;
    assign drop_count    = r_drops;

endmodule

// File: doc/queue_fifo.md
# queue_fifo

Parametrised successor to the byte queue: a single-clock FIFO with configurable data width and depth, full-capacity occupancy tracking, a selectable overflow policy (drop-newest or overwrite-oldest), a sticky overflow flag with explicit clear, and a saturating drop counter. It sits between byte/word producers (UART RX, command parsers) and consumers that pop with an acknowledge.

## Interface
- `WIDTH`, 8: data word width in bits.
- `SIZE`, 16: depth in words; must be a power of two, ≥ 2. `ADDRSIZE = $clog2(SIZE)`.
- `OVERWRITE`, 0: overflow policy. 0 drops the incoming word; 1 discards the oldest word and accepts the new one.
- `AFULL_THRESH`, SIZE-2: `almost_full` asserts when `level ≥ AFULL_THRESH`.

Ports:
- `clk` in 1: sole clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `in_data` in WIDTH: write data.
- `in_en` in 1: write request, one word per cycle.
- `out_data` out WIDTH: head word; valid when `out_available`=1.
- `out_available` out 1: FIFO non-empty.
- `out_ack` in 1: pop head; ignored when `out_available`=0.
- `level` out ADDRSIZE+1: current occupancy, 0..SIZE.
- `full` out 1: `level == SIZE`.
- `almost_full` out 1: `level ≥ AFULL_THRESH`.
- `overflow` out 1: sticky; set on any write while full without a same-cycle pop.
- `overflow_clr` in 1: clears `overflow`.
- `drop_count` out 8: number of words lost; saturates at 255.

## Operation
- State: `wr_ptr`, `rd_ptr` (ADDRSIZE bits, wrap modulo SIZE), `level` register, memory array (not reset).
- All SIZE entries usable; full/empty are derived from `level`, never from pointer comparison.
- Push: `in_en` & (!full | pop) → mem[wr_ptr] ← in_data, wr_ptr+1.
- Pop: `out_ack` & `out_available` → rd_ptr+1.
- Full, `in_en`, no pop:
  - OVERWRITE=0: word dropped; pointers and level unchanged.
  - OVERWRITE=1: write at wr_ptr, both pointers advance, level stays SIZE.
  - Both modes: `overflow`←1, `drop_count`+1 (saturating).
- Full, push and pop together: both proceed, level unchanged, no overflow.
- Empty, push and ack together: push only; ack ignored.
- `level` next = level + push_accepted − pop_accepted (overwrite case counts as net 0).
- `overflow_clr` and a new overflow event in the same cycle: `overflow` remains 1.
- `drop_count` is cleared only by reset.

## Timing
- Reset values: `out_available`=0, `level`=0, `full`=0, `almost_full`=0 (unless AFULL_THRESH=0, then 1), `overflow`=0, `drop_count`=0. `out_data` is undefined until the first word is written.
- While `rst`=1, `in_en` and `out_ack` are ignored. Reset mid-operation discards all contents.
- Write-to-read latency: a word written at edge N is visible on `out_data` with `out_available`=1 after edge N (first-word fall-through from registered pointers).
- `out_data`/`out_available`/`level`/flags all reflect register state after the last edge; no combinational path from `in_en`/`out_ack` to any output.
- After a pop at edge N, `out_data` shows the next word after edge N.
- Sustained throughput: one push and one pop per cycle.

## Structure
- Package `queue_pkg`: overflow-policy constants (`Q_DROP_NEW`=0, `Q_OVERWRITE_OLD`=1) and the `DROP_CNT_W`=8 constant.
- One sub-module `queue_ram`: parametrised WIDTH×SIZE array, synchronous write port, asynchronous read port. Control stays in `queue_fifo`.

## Test plan
- Reset, then write 0x11..0x1F + 0x10 (16 words, SIZE=16) with no pops → `full`=1, `level`=16, `overflow`=0; drain → words come out in order 0x11..0x10, `out_available` drops after the 16th ack.
- OVERWRITE=0, full, write 0xAA → `overflow`=1, `drop_count`=1, head still the first word, 0xAA never read.
- OVERWRITE=1, full of 0..15, write 0xAA → head becomes 1, last word read is 0xAA, `level`=16, `drop_count`=1.
- Full with simultaneous push 0x55 and ack → `overflow` stays 0, `level`=16, 0x55 read last; empty with push 0x77 and ack → `level`=1, head 0x77.
- Assert `overflow_clr` and an overflowing write together → `overflow`=1; `overflow_clr` alone next cycle → 0; 300 drops → `drop_count`=255.
- Assert `rst` with `level`=5 and `in_en`=1 → after that edge `level`=0, `out_available`=0, `overflow`=0; the first post-reset write is read back correctly.
